// File: rtl/msx_ram_arbiter_if.sv
// Bus bundle between the CPU slot decoder, the bulk loader, the arbiter and the memory port.
// slave = arbiter view, master = requesters plus memory view.
interface msx_ram_arbiter_if #(
  parameter int ADDR_W = 27
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_din;
  logic              cpu_rnw;
  logic              cpu_bram;
  logic              cpu_ack;
  logic [7:0]        cpu_dout;
  logic              cpu_wait_n;

  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_din;
  logic              ld_bram;
  logic              ld_ack;

  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_din;
  logic              ram_rnw;
  logic              sdram_ce;
  logic              bram_ce;
  logic [7:0]        ram_dout;
  logic              sdram_ready;

  modport slave (
    input  cpu_req, cpu_addr, cpu_din, cpu_rnw, cpu_bram,
    output cpu_ack, cpu_dout, cpu_wait_n,
    input  ld_req, ld_addr, ld_din, ld_bram,
    output ld_ack,
    output ram_addr, ram_din, ram_rnw, sdram_ce, bram_ce,
    input  ram_dout, sdram_ready
  );

  modport master (
    output cpu_req, cpu_addr, cpu_din, cpu_rnw, cpu_bram,
    input  cpu_ack, cpu_dout, cpu_wait_n,
    output ld_req, ld_addr, ld_din, ld_bram,
    input  ld_ack,
    input  ram_addr, ram_din, ram_rnw, sdram_ce, bram_ce,
    output ram_dout, sdram_ready
  );
endinterface

// File: rtl/msx_ram_arbiter.sv
// Memory port arbiter: CPU slot accesses vs. bulk loader, CPU first with a loader starvation bound.
// Optional SDRAM wait watchdog with sticky arb_timeout flag: define MSX_RAM_ARB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | sample requests, grant and latch the access
// ISSUE  | one-cycle bram_ce / sdram_ce strobe
// WAIT   | BRAM latency countdown or wait for sdram_ready
// DONE   | ack pulse to the owner, then back to IDLE
module msx_ram_arbiter #(
  parameter int ADDR_W     = 27,
  parameter int BRAM_LAT   = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic clk21m,
  input  logic reset,
  msx_ram_arbiter_if.slave bus
`ifdef MSX_RAM_ARB_TIMEOUT_EN
  ,
  output logic arb_timeout
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_own_cpu;
  logic              r_tgt_bram;
  logic [2:0]        r_lat_cnt;
  logic [3:0]        r_starve;
  logic              r_cpu_ack;
  logic              r_ld_ack;
  logic              r_sdram_ce;
  logic              r_bram_ce;
  logic              r_ram_rnw;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [7:0]        r_ram_din;
  logic [7:0]        r_cpu_dout;

  logic w_cpu_grant;
  logic w_wait_exit;
  logic w_timeout;

  assign w_cpu_grant = bus.cpu_req && (!bus.ld_req || (r_starve < 4'(STARVE_MAX)));
  assign w_wait_exit = r_tgt_bram ? (r_lat_cnt == 3'd1) : bus.sdram_ready;

`ifdef MSX_RAM_ARB_TIMEOUT_EN
  logic [7:0] r_wdog;
  logic       r_arb_timeout;
  // r_wdog counts completed WAIT cycles, so 254 marks the 255th one
  assign w_timeout   = !r_tgt_bram && !bus.sdram_ready && (r_wdog == 8'd254);
  assign arb_timeout = r_arb_timeout;
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_own_cpu  <= 1'b0;
      r_tgt_bram <= 1'b0;
      r_lat_cnt  <= 3'd0;
      r_starve   <= 4'd0;
      r_cpu_ack  <= 1'b0;
      r_ld_ack   <= 1'b0;
      r_sdram_ce <= 1'b0;
      r_bram_ce  <= 1'b0;
      r_ram_rnw  <= 1'b1;
      r_ram_addr <= '0;
      r_ram_din  <= 8'd0;
      r_cpu_dout <= 8'd0;
`ifdef MSX_RAM_ARB_TIMEOUT_EN
      r_wdog        <= 8'd0;
      r_arb_timeout <= 1'b0;
`endif
    end else begin
      r_cpu_ack  <= 1'b0;
      r_ld_ack   <= 1'b0;
      r_sdram_ce <= 1'b0;
      r_bram_ce  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cpu_grant) begin
            r_own_cpu  <= 1'b1;
            r_tgt_bram <= bus.cpu_bram;
            r_ram_addr <= bus.cpu_addr;
            r_ram_din  <= bus.cpu_din;
            r_ram_rnw  <= bus.cpu_rnw;
            r_bram_ce  <= bus.cpu_bram;
            r_sdram_ce <= !bus.cpu_bram;
            r_state    <= S_ISSUE;
            if (!bus.ld_req)
              r_starve <= 4'd0;
            else if (r_starve != 4'hF)
              r_starve <= r_starve + 4'd1;
          end else if (bus.ld_req) begin
            r_own_cpu  <= 1'b0;
            r_tgt_bram <= bus.ld_bram;
            r_ram_addr <= bus.ld_addr;
            r_ram_din  <= bus.ld_din;
            r_ram_rnw  <= 1'b0;
            r_bram_ce  <= bus.ld_bram;
            r_sdram_ce <= !bus.ld_bram;
            r_state    <= S_ISSUE;
            r_starve   <= 4'd0;
          end else begin
            r_starve <= 4'd0;
          end
        end
        S_ISSUE: begin
          r_lat_cnt <= 3'(BRAM_LAT);
`ifdef MSX_RAM_ARB_TIMEOUT_EN
          r_wdog <= 8'd0;
`endif
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_wait_exit || w_timeout) begin
            if (r_own_cpu && r_ram_rnw)
              r_cpu_dout <= w_timeout ? 8'hFF : bus.ram_dout;
            if (r_own_cpu)
              r_cpu_ack <= 1'b1;
            else
              r_ld_ack <= 1'b1;
            // direction returns to read as the ack goes out, so DONE already shows rnw = 1
            r_ram_rnw <= 1'b1;
            r_state   <= S_DONE;
`ifdef MSX_RAM_ARB_TIMEOUT_EN
            if (w_timeout)
              r_arb_timeout <= 1'b1;
`endif
          end else begin
            if (r_tgt_bram)
              r_lat_cnt <= r_lat_cnt - 3'd1;
`ifdef MSX_RAM_ARB_TIMEOUT_EN
            else
              r_wdog <= r_wdog + 8'd1;
`endif
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cpu_ack    = r_cpu_ack;
  assign bus.ld_ack     = r_ld_ack;
  assign bus.cpu_dout   = r_cpu_dout;
  assign bus.cpu_wait_n = ~bus.cpu_req | r_cpu_ack;
  assign bus.ram_addr   = r_ram_addr;
  assign bus.ram_din    = r_ram_din;
  assign bus.ram_rnw    = r_ram_rnw;
  assign bus.sdram_ce   = r_sdram_ce;
  assign bus.bram_ce    = r_bram_ce;

endmodule

// File: tb/tb_msx_ram_arbiter.sv
// Directed bench for msx_ram_arbiter: BRAM/SDRAM timing, loader writes, starvation, reset abort.
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_msx_ram_arbiter;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   who;
`ifdef MSX_RAM_ARB_TIMEOUT_EN
  logic arb_timeout;
`endif

  msx_ram_arbiter_if #(.ADDR_W(27)) bus ();

  msx_ram_arbiter #(.ADDR_W(27), .BRAM_LAT(1), .STARVE_MAX(8)) dut (
    .clk21m (clk),
    .reset  (rst),
    .bus    (bus)
`ifdef MSX_RAM_ARB_TIMEOUT_EN
    ,
    .arb_timeout (arb_timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(output int owner);
    owner = 0;
    for (int i = 0; i < 10 && owner == 0; i++) begin
      tick();
      if (bus.cpu_ack) owner = 1;
      else if (bus.ld_ack) owner = 2;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.cpu_din = 8'h00; bus.cpu_rnw = 1'b1; bus.cpu_bram = 1'b0;
    bus.ld_req = 1'b0; bus.ld_addr = '0; bus.ld_din = 8'h00; bus.ld_bram = 1'b0;
    bus.ram_dout = 8'h00; bus.sdram_ready = 1'b0;
    #1;
    chk("rst_cpu_ack", bus.cpu_ack, 0);
    chk("rst_ld_ack", bus.ld_ack, 0);
    chk("rst_ce", {bus.sdram_ce, bus.bram_ce}, 0);
    chk("rst_rnw", bus.ram_rnw, 1);
    chk("rst_addr", bus.ram_addr, 0);
    chk("rst_dout", bus.cpu_dout, 0);
`ifdef MSX_RAM_ARB_TIMEOUT_EN
    chk("rst_timeout", arb_timeout, 0);
`endif
    tick();
    rst = 1'b0;

    // CPU BRAM read, cycle k = request cycle
    bus.cpu_req = 1'b1; bus.cpu_addr = 27'h0001234; bus.cpu_rnw = 1'b1; bus.cpu_bram = 1'b1;
    bus.ram_dout = 8'h5A;
    #1;
    chk("t1_wait_k", bus.cpu_wait_n, 0);
    chk("t1_bce_k", bus.bram_ce, 0);
    tick();
    chk("t1_bce_k1", bus.bram_ce, 1);
    chk("t1_sce_k1", bus.sdram_ce, 0);
    chk("t1_addr", bus.ram_addr, 27'h0001234);
    chk("t1_rnw", bus.ram_rnw, 1);
    chk("t1_wait_k1", bus.cpu_wait_n, 0);
    tick();
    chk("t1_bce_k2", bus.bram_ce, 0);
    chk("t1_ack_k2", bus.cpu_ack, 0);
    chk("t1_wait_k2", bus.cpu_wait_n, 0);
    tick();
    chk("t1_ack_k3", bus.cpu_ack, 1);
    chk("t1_dout", bus.cpu_dout, 8'h5A);
    chk("t1_wait_k3", bus.cpu_wait_n, 1);
    chk("t1_rnw_done", bus.ram_rnw, 1);
    bus.cpu_req = 1'b0;
    bus.ram_dout = 8'h11;
    tick();
    chk("t1_ack_off", bus.cpu_ack, 0);
    chk("t1_dout_hold", bus.cpu_dout, 8'h5A);
    chk("t1_starve", dut.r_starve, 0);

    // Loader SDRAM write, ready raised 5 cycles after ISSUE
    bus.ld_req = 1'b1; bus.ld_addr = 27'h0100000; bus.ld_din = 8'hC3; bus.ld_bram = 1'b0;
    tick();
    chk("t2_sce", bus.sdram_ce, 1);
    chk("t2_bce", bus.bram_ce, 0);
    chk("t2_rnw", bus.ram_rnw, 0);
    chk("t2_din", bus.ram_din, 8'hC3);
    chk("t2_addr", bus.ram_addr, 27'h0100000);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_sce_once", bus.sdram_ce, 0);
      chk("t2_no_ack", bus.ld_ack, 0);
      chk("t2_rnw_stable", bus.ram_rnw, 0);
    end
    bus.sdram_ready = 1'b1;
    tick();
    chk("t2_ld_ack", bus.ld_ack, 1);
    chk("t2_cpu_ack", bus.cpu_ack, 0);
    chk("t2_rnw_done", bus.ram_rnw, 1);
    chk("t2_dout_hold", bus.cpu_dout, 8'h5A);
    bus.sdram_ready = 1'b0;
    bus.ld_req = 1'b0;
    tick();
    chk("t2_ack_off", bus.ld_ack, 0);

    // Starvation: both requesters hold their request
    bus.cpu_req = 1'b1; bus.cpu_bram = 1'b1; bus.cpu_rnw = 1'b1; bus.cpu_addr = 27'h0000010;
    bus.ld_req = 1'b1; bus.ld_bram = 1'b1; bus.ld_addr = 27'h0000020; bus.ld_din = 8'h3C;
    for (int j = 1; j <= 9; j++) begin
      wait_ack(who);
      chk("t3_owner", who, (j <= 8) ? 1 : 2);
      chk("t3_starve", dut.r_starve, (j <= 8) ? j : 0);
    end
    bus.cpu_req = 1'b0;
    bus.ld_req = 1'b0;
    tick();
    chk("t3_starve_idle", dut.r_starve, 0);

    // Reset in WAIT of an SDRAM CPU read
    bus.cpu_req = 1'b1; bus.cpu_bram = 1'b0; bus.cpu_rnw = 1'b1; bus.cpu_addr = 27'h0ABCDEF;
    bus.ram_dout = 8'h77;
    tick();
    chk("t4_sce", bus.sdram_ce, 1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("t4_rst_ack", bus.cpu_ack, 0);
    chk("t4_rst_addr", bus.ram_addr, 0);
    chk("t4_rst_dout", bus.cpu_dout, 0);
    chk("t4_rst_rnw", bus.ram_rnw, 1);
    chk("t4_rst_state", dut.r_state, 0);
    bus.sdram_ready = 1'b1;
    tick();
    tick();
    chk("t4_no_ack", bus.cpu_ack, 0);
    bus.sdram_ready = 1'b0;
    rst = 1'b0;
    tick();
    chk("t4_re_sce", bus.sdram_ce, 1);
    chk("t4_re_addr", bus.ram_addr, 27'h0ABCDEF);
    bus.sdram_ready = 1'b1;
    tick();
    chk("t4_re_noack", bus.cpu_ack, 0);
    tick();
    chk("t4_re_ack", bus.cpu_ack, 1);
    chk("t4_re_dout", bus.cpu_dout, 8'h77);
    bus.sdram_ready = 1'b0;
    bus.cpu_req = 1'b0;
    tick();

    // CPU BRAM write at the top address, loader idle
    bus.cpu_req = 1'b1; bus.cpu_bram = 1'b1; bus.cpu_rnw = 1'b0; bus.cpu_addr = 27'h7FFFFFF;
    bus.cpu_din = 8'hA5;
    chk("t5_rnw_idle", bus.ram_rnw, 1);
    tick();
    chk("t5_rnw_issue", bus.ram_rnw, 0);
    chk("t5_din", bus.ram_din, 8'hA5);
    chk("t5_addr", bus.ram_addr, 27'h7FFFFFF);
    tick();
    chk("t5_rnw_wait", bus.ram_rnw, 0);
    tick();
    chk("t5_ack", bus.cpu_ack, 1);
    chk("t5_rnw_done", bus.ram_rnw, 1);
    chk("t5_dout_keep", bus.cpu_dout, 8'h77);
    bus.cpu_req = 1'b0;
    tick();
    chk("t5_rnw_idle2", bus.ram_rnw, 1);
    chk("t5_addr_hold", bus.ram_addr, 27'h7FFFFFF);
    chk("t5_starve", dut.r_starve, 0);

`ifdef MSX_RAM_ARB_TIMEOUT_EN
    bus.cpu_req = 1'b1; bus.cpu_bram = 1'b0; bus.cpu_rnw = 1'b1; bus.cpu_addr = 27'h0000400;
    tick();
    for (int i = 0; i < 255; i++) tick();
    chk("t6_no_ack_yet", bus.cpu_ack, 0);
    tick();
    chk("t6_ack", bus.cpu_ack, 1);
    chk("t6_dout", bus.cpu_dout, 8'hFF);
    chk("t6_flag", arb_timeout, 1);
    bus.cpu_req = 1'b0;
    tick();
    tick();
    chk("t6_flag_sticky", arb_timeout, 1);
    rst = 1'b1;
    #1;
    chk("t6_flag_rst", arb_timeout, 0);
    tick();
    rst = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
